// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state encoding, byte type and S-box depth for the RC4 cipher
package rc4_pkg;

  localparam int SBOX_DEPTH = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    INIT,
    LOAD,
    KSA,
    DROP,
    CRYPT
  } state_t;

endpackage

// File: rtl/rc4_if.sv
// rtl/rc4_if.sv - key load, data in/out handshakes and control for the RC4 cipher
interface rc4_if;
  import rc4_pkg::*;

  logic  key_valid;
  logic  key_ready;
  byte_t key_data;
  logic  in_valid;
  logic  in_ready;
  byte_t in_data;
  logic  out_valid;
  logic  out_ready;
  byte_t out_data;
  logic  ks_done;
  logic  rekey;

  modport master (
    output key_valid, key_data, in_valid, in_data, out_ready, rekey,
    input  key_ready, in_ready, out_valid, out_data, ks_done
  );

  modport slave (
    input  key_valid, key_data, in_valid, in_data, out_ready, rekey,
    output key_ready, in_ready, out_valid, out_data, ks_done
  );

endinterface

// File: rtl/rc4_sbox.sv
// rtl/rc4_sbox.sv - 256x8 S-box flops: three async read ports, two-port swap write, identity fill
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic  clk,
  input  logic  init_en,
  input  byte_t init_addr,
  input  byte_t rd_addr0,
  input  byte_t rd_addr1,
  input  byte_t rd_addr2,
  output byte_t rd_data0,
  output byte_t rd_data1,
  output byte_t rd_data2,
  input  logic  swap_en,
  input  byte_t wr_addr0,
  input  byte_t wr_data0,
  input  byte_t wr_addr1,
  input  byte_t wr_data1
);

  byte_t mem [SBOX_DEPTH];

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];

  // Equal swap addresses carry equal data, so the double write is harmless.
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_addr] <= init_addr;
    end else if (swap_en) begin
      mem[wr_addr0] <= wr_data0;
      mem[wr_addr1] <= wr_data1;
    end
  end

endmodule

// File: rtl/rc4_cipher.sv
// rtl/rc4_cipher.sv - RC4 FSM, key store, keystream bypass and XOR; RC4_DROP_EN enables the drop phase
module rc4_cipher
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = 8,
  parameter int DROP_N  = 768
) (
  input  logic  clk,
  input  logic  rst,
  rc4_if.slave  bus
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int CW = ($clog2(DROP_N + 1) > 8) ? $clog2(DROP_N + 1) : 8;
  localparam logic [KW-1:0] LAST_K = KW'(KEY_LEN - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] kidx;
  byte_t         i;
  byte_t         j;
  byte_t         key_mem [KEY_LEN];

  logic  key_ready_q;
  logic  out_valid_q;
  logic  ks_done_q;
  byte_t out_data_q;

  byte_t s0, s1, s2;
  byte_t addr0, i1, j_next, t, ks;
  logic  in_ready_c, in_fire, out_fire, key_fire;
  logic  rekey_ok, crypt_fire, prga_step, swap_en;

  // One datapath serves both KSA and PRGA: only the first read address and the key term differ.
  assign i1     = i + 8'd1;
  assign addr0  = (state == KSA) ? cnt[7:0] : i1;
  assign j_next = (state == KSA) ? (j + s0 + key_mem[kidx]) : (j + s0);
  assign t      = s0 + s1;
  assign ks     = (t == i1) ? s1 : ((t == j_next) ? s0 : s2);

  assign in_ready_c = (state == CRYPT) && (!out_valid_q || bus.out_ready);
  assign in_fire    = bus.in_valid && in_ready_c;
  assign out_fire   = out_valid_q && bus.out_ready;
  assign key_fire   = bus.key_valid && key_ready_q;
  assign rekey_ok   = bus.rekey && (state == CRYPT) && !out_valid_q;
  // A rekey in the same cycle as an input byte wins; that byte is discarded.
  assign crypt_fire = in_fire && !rekey_ok;

`ifdef RC4_DROP_EN
  assign prga_step = (state == DROP) || crypt_fire;
`else
  assign prga_step = crypt_fire;
`endif
  assign swap_en = (state == KSA) || prga_step;

  rc4_sbox u_sbox (
    .clk       (clk),
    .init_en   (state == INIT),
    .init_addr (cnt[7:0]),
    .rd_addr0  (addr0),
    .rd_addr1  (j_next),
    .rd_addr2  (t),
    .rd_data0  (s0),
    .rd_data1  (s1),
    .rd_data2  (s2),
    .swap_en   (swap_en),
    .wr_addr0  (addr0),
    .wr_data0  (s1),
    .wr_addr1  (j_next),
    .wr_data1  (s0)
  );

  always_ff @(posedge clk) begin
    if (state == LOAD && key_fire) begin
      key_mem[kidx] <= bus.key_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      cnt         <= '0;
      kidx        <= '0;
      i           <= '0;
      j           <= '0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ks_done_q   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(255)) begin
            state       <= LOAD;
            cnt         <= '0;
            kidx        <= '0;
            i           <= '0;
            j           <= '0;
            key_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (key_fire) begin
            if (kidx == LAST_K) begin
              kidx        <= '0;
              state       <= KSA;
              key_ready_q <= 1'b0;
            end else begin
              kidx <= kidx + KW'(1);
            end
          end
        end
        KSA: begin
          j    <= j_next;
          kidx <= (kidx == LAST_K) ? '0 : kidx + KW'(1);
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(255)) begin
            cnt <= '0;
            i   <= '0;
            j   <= '0;
`ifdef RC4_DROP_EN
            state <= DROP;
`else
            state     <= CRYPT;
            ks_done_q <= 1'b1;
`endif
          end
        end
`ifdef RC4_DROP_EN
        DROP: begin
          i   <= i1;
          j   <= j_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DROP_N - 1)) begin
            cnt       <= '0;
            state     <= CRYPT;
            ks_done_q <= 1'b1;
          end
        end
`endif
        CRYPT: begin
          if (rekey_ok) begin
            state     <= INIT;
            cnt       <= '0;
            ks_done_q <= 1'b0;
          end else if (in_fire) begin
            i           <= i1;
            j           <= j_next;
            out_data_q  <= bus.in_data ^ ks;
            out_valid_q <= 1'b1;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ks_done   = ks_done_q;

endmodule

// File: tb/tb_rc4_cipher.sv
// tb/tb_rc4_cipher.sv - randomized bench for rc4_cipher against a behavioural RC4 model; honours RC4_DROP_EN
module tb_rc4_cipher;

  localparam int KEY_LEN = 12;
  localparam int DROP_N  = 768;
`ifdef RC4_DROP_EN
  localparam int EXP_SETUP = 256 + KEY_LEN + 256 + DROP_N;
`else
  localparam int EXP_SETUP = 256 + KEY_LEN + 256;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc4_if bus ();

  rc4_cipher #(.KEY_LEN(KEY_LEN), .DROP_N(DROP_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Textbook RC4 state; keys shorter than KEY_LEN are repeated to fill the DUT's key file.
  int m_s [256];
  int m_i;
  int m_j;

  function automatic logic [7:0] model_ks();
    int tmp;
    m_i = (m_i + 1) % 256;
    m_j = (m_j + m_s[m_i]) % 256;
    tmp = m_s[m_i];
    m_s[m_i] = m_s[m_j];
    m_s[m_j] = tmp;
    return 8'(m_s[(m_s[m_i] + m_s[m_j]) % 256]);
  endfunction

  function automatic void model_key(input logic [7:0] key[$]);
    int jj;
    int tmp;
    jj = 0;
    for (int n = 0; n < 256; n++) m_s[n] = n;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + m_s[n] + int'(key[n % key.size()])) % 256;
      tmp = m_s[n];
      m_s[n] = m_s[jj];
      m_s[jj] = tmp;
    end
    m_i = 0;
    m_j = 0;
`ifdef RC4_DROP_EN
    for (int n = 0; n < DROP_N; n++) void'(model_ks());
`endif
  endfunction

  task automatic setup(input logic [7:0] key[$], input int limit, output int cycles);
    int   k;
    logic fire;
    k = 0;
    cycles = 0;
    while (!bus.ks_done && cycles < limit) begin
      bus.key_valid = (k < KEY_LEN);
      bus.key_data  = key[k % key.size()];
      fire = bus.key_valid && bus.key_ready;
      @(posedge clk);
      cycles++;
      if (fire) k++;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
  endtask

  task automatic full_setup(input logic [7:0] key[$], input string name);
    int cyc;
    setup(key, EXP_SETUP + 64, cyc);
    n_cmp++;
    if (bus.ks_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ks_done: got %b want 1 after %0d cycles", name, bus.ks_done, cyc);
    end
    n_cmp++;
    if (cyc != EXP_SETUP) begin
      n_err++;
      $display("FAIL %s_setup_cycles: got %0d want %0d", name, cyc, EXP_SETUP);
    end
  endtask

  task automatic stream(input logic [7:0] din[$], input bit rand_ready,
                        output logic [7:0] dout[$], output int cycles);
    logic [7:0] q[$];
    logic [7:0] held;
    bit   stalled;
    logic in_fire;
    int   idx;
    int   limit;
    idx = 0;
    stalled = 0;
    held = 8'h00;
    cycles = 0;
    limit = din.size() * 8 + 64;
    while ((idx < din.size() || bus.out_valid) && cycles < limit) begin
      if (stalled) begin
        n_cmp++;
        if (bus.out_data !== held) begin
          n_err++;
          $display("FAIL stall_stable: got %h want %h", bus.out_data, held);
        end
      end
      bus.in_valid = (idx < din.size());
      if (idx < din.size()) bus.in_data = din[idx];
      else bus.in_data = 8'h00;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      in_fire = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) q.push_back(bus.out_data);
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      @(posedge clk);
      cycles++;
      if (in_fire) idx++;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (q.size() != din.size()) begin
      n_err++;
      $display("FAIL stream_count: got %0d bytes want %0d", q.size(), din.size());
    end
    dout = q;
  endtask

  task automatic do_rekey();
    bus.rekey = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rekey = 1'b0;
    n_cmp++;
    if (bus.ks_done !== 1'b0) begin
      n_err++;
      $display("FAIL rekey_ks_done: got %b want 0", bus.ks_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_data  = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.rekey     = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (bus.key_ready !== 1'b0) begin n_err++; $display("FAIL reset_key_ready: got %b want 0", bus.key_ready); end
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    if (bus.ks_done !== 1'b0) begin n_err++; $display("FAIL reset_ks_done: got %b want 0", bus.ks_done); end
    rst = 1'b0;
  endtask

  task automatic run_vector(input logic [7:0] key[$], input logic [7:0] din[$],
                            input logic [7:0] exp_c[$], input string name);
    logic [7:0] dout[$];
    logic [7:0] exp;
    int cyc;
    model_key(key);
    full_setup(key, name);
    stream(din, 1'b0, dout, cyc);
    for (int n = 0; n < din.size() && n < dout.size(); n++) begin
`ifdef RC4_DROP_EN
      exp = din[n] ^ model_ks();
`else
      exp = exp_c[n];
`endif
      n_cmp++;
      if (dout[n] !== exp) begin
        n_err++;
        $display("FAIL %s_byte%0d: got %h want %h", name, n, dout[n], exp);
      end
    end
  endtask

  task automatic test_vectors();
    run_vector('{8'h4B, 8'h65, 8'h79},
               '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74},
               '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3}, "vec_key");
    do_rekey();
    run_vector('{8'h57, 8'h69, 8'h6B, 8'h69},
               '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61},
               '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20}, "vec_wiki");
  endtask

  task automatic test_round_trip();
    logic [7:0] key[$];
    logic [7:0] din[$], enc[$], dec[$];
    logic [7:0] exp;
    int cyc;
    for (int n = 0; n < 8; n++) key.push_back(8'h42);
    for (int n = 0; n < 2000; n++) din.push_back(8'($urandom));
    do_rekey();
    model_key(key);
    full_setup(key, "rt_enc");
    stream(din, 1'b0, enc, cyc);
    n_cmp++;
    if (cyc != din.size() + 1) begin
      n_err++;
      $display("FAIL rt_throughput: got %0d cycles want %0d", cyc, din.size() + 1);
    end
    for (int n = 0; n < enc.size(); n++) begin
      exp = din[n] ^ model_ks();
      n_cmp++;
      if (enc[n] !== exp) begin n_err++; $display("FAIL rt_enc_byte%0d: got %h want %h", n, enc[n], exp); end
    end
    do_rekey();
    full_setup(key, "rt_dec");
    stream(enc, 1'b0, dec, cyc);
    for (int n = 0; n < dec.size(); n++) begin
      n_cmp++;
      if (dec[n] !== din[n]) begin n_err++; $display("FAIL rt_dec_byte%0d: got %h want %h", n, dec[n], din[n]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] key[$];
    logic [7:0] din[$], dout[$];
    logic [7:0] x, exp;
    int cyc;
    for (int n = 0; n < KEY_LEN; n++) key.push_back(8'($urandom));
    for (int n = 0; n < 300; n++) din.push_back(8'($urandom));
    do_rekey();
    model_key(key);
    full_setup(key, "bp");
    stream(din, 1'b1, dout, cyc);
    for (int n = 0; n < dout.size(); n++) begin
      exp = din[n] ^ model_ks();
      n_cmp++;
      if (dout[n] !== exp) begin n_err++; $display("FAIL bp_byte%0d: got %h want %h", n, dout[n], exp); end
    end
    // A rekey while a result is pending must be ignored.
    x = 8'($urandom);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rekey    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rekey = 1'b0;
    exp = x ^ model_ks();
    n_cmp += 3;
    if (bus.ks_done !== 1'b1) begin n_err++; $display("FAIL rekey_ignored_ks_done: got %b want 1", bus.ks_done); end
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rekey_ignored_valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== exp) begin n_err++; $display("FAIL rekey_ignored_data: got %h want %h", bus.out_data, exp); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
    din = {};
    for (int n = 0; n < 16; n++) din.push_back(8'($urandom));
    stream(din, 1'b0, dout, cyc);
    for (int n = 0; n < dout.size(); n++) begin
      exp = din[n] ^ model_ks();
      n_cmp++;
      if (dout[n] !== exp) begin n_err++; $display("FAIL after_rekey_byte%0d: got %h want %h", n, dout[n], exp); end
    end
  endtask

  task automatic test_reset_mid_ksa();
    logic [7:0] key[$];
    logic [7:0] din[$], dout[$];
    logic [7:0] exp;
    int cyc;
    for (int n = 0; n < KEY_LEN; n++) key.push_back(8'($urandom));
    for (int n = 0; n < 64; n++) din.push_back(8'($urandom));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    setup(key, 256 + KEY_LEN + 100, cyc);
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (bus.ks_done !== 1'b0) begin n_err++; $display("FAIL midksa_ks_done: got %b want 0", bus.ks_done); end
    if (bus.key_ready !== 1'b0) begin n_err++; $display("FAIL midksa_key_ready: got %b want 0", bus.key_ready); end
    rst = 1'b0;
    model_key(key);
    full_setup(key, "midksa");
    stream(din, 1'b0, dout, cyc);
    for (int n = 0; n < dout.size(); n++) begin
      exp = din[n] ^ model_ks();
      n_cmp++;
      if (dout[n] !== exp) begin n_err++; $display("FAIL midksa_byte%0d: got %h want %h", n, dout[n], exp); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_round_trip();
    test_backpressure();
    test_reset_mid_ksa();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
